// File: rtl/memory_bus_controller.sv
// External memory bus sequencer: 20-bit byte addresses, 16-bit bus, odd word accesses split into two byte cycles.
// Optional wait-state abort enabled by defining BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module memory_bus_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_word,
    input  logic [19:0] req_address,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_error,
    output logic [19:0] bus_address,
    output logic [1:0]  bus_byte_enable,
    output logic        bus_read,
    output logic        bus_write,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ready
);
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BE_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CYCLE1 = 2'd1,
        CYCLE2 = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic              word;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } req_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q;
    state_e            state_next;
    req_t              req_in;
    req_t              req_q;
    req_t              req_sel;
    logic              accept;
    logic              split_q;
    logic              timeout_hit;
    logic [BYTE_W-1:0] rdata_lo_q;
    logic [DATA_W-1:0] read_result;

    logic              req_ready_next;
    logic              resp_valid_next;
    logic [DATA_W-1:0] resp_rdata_next;
    logic              resp_error_next;
    logic [ADDR_W-1:0] bus_address_next;
    logic [BE_W-1:0]   bus_byte_enable_next;
    logic              bus_read_next;
    logic              bus_write_next;
    logic [DATA_W-1:0] bus_wdata_next;

    assign req_in  = {req_write, req_word, req_address, req_wdata};
    assign split_q = req_q.word & req_q.address[0];

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Counts consecutive not-ready cycles of the bus cycle in flight.
    assign timeout_hit = (state_q != IDLE) && !bus_ready
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin : wait_counter
        if (reset) begin
            wait_cnt_q <= '0;
        end else if ((state_q == IDLE) || bus_ready || timeout_hit) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin : state_reg
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin : next_state_comb
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_next = CYCLE1;
                end
            end
            CYCLE1: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (bus_ready) begin
                    state_next = split_q ? CYCLE2 : IDLE;
                end
            end
            CYCLE2: begin
                if (timeout_hit || bus_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus drive and response values for the cycle after the coming edge.
    always_comb begin : output_comb
        accept               = (state_q == IDLE) && req_valid;
        req_sel              = accept ? req_in : req_q;
        req_ready_next       = (state_next == IDLE);
        bus_read_next        = 1'b0;
        bus_write_next       = 1'b0;
        bus_address_next     = '0;
        bus_byte_enable_next = '0;
        bus_wdata_next       = '0;
        read_result          = '0;
        resp_valid_next      = 1'b0;
        resp_error_next      = 1'b0;
        resp_rdata_next      = resp_rdata;

        case (state_next)
            CYCLE1: begin
                bus_read_next    = ~req_sel.write;
                bus_write_next   = req_sel.write;
                bus_address_next = req_sel.address;
                // Odd byte and the first half of an odd word both use the odd lane.
                if (req_sel.address[0]) begin
                    bus_byte_enable_next = 2'b10;
                    bus_wdata_next       = {req_sel.wdata[BYTE_W-1:0], {BYTE_W{1'b0}}};
                end else if (req_sel.word) begin
                    bus_byte_enable_next = 2'b11;
                    bus_wdata_next       = req_sel.wdata;
                end else begin
                    bus_byte_enable_next = 2'b01;
                    bus_wdata_next       = {{BYTE_W{1'b0}}, req_sel.wdata[BYTE_W-1:0]};
                end
            end
            CYCLE2: begin
                bus_read_next        = ~req_sel.write;
                bus_write_next       = req_sel.write;
                bus_address_next     = req_sel.address + ADDR_W'(1);
                bus_byte_enable_next = 2'b01;
                bus_wdata_next       = {{BYTE_W{1'b0}}, req_sel.wdata[DATA_W-1:BYTE_W]};
            end
            default: ;
        endcase

        if (state_q == CYCLE2) begin
            read_result = {bus_rdata[BYTE_W-1:0], rdata_lo_q};
        end else if (req_q.address[0]) begin
            read_result = {{BYTE_W{1'b0}}, bus_rdata[DATA_W-1:BYTE_W]};
        end else if (req_q.word) begin
            read_result = bus_rdata;
        end else begin
            read_result = {{BYTE_W{1'b0}}, bus_rdata[BYTE_W-1:0]};
        end

        if ((state_q != IDLE) && (state_next == IDLE)) begin
            resp_valid_next = 1'b1;
            resp_error_next = timeout_hit;
            resp_rdata_next = (timeout_hit || req_q.write) ? '0 : read_result;
        end
    end

    always_ff @(posedge clock) begin : output_reg
        if (reset) begin
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_error      <= 1'b0;
            bus_address     <= '0;
            bus_byte_enable <= '0;
            bus_read        <= 1'b0;
            bus_write       <= 1'b0;
            bus_wdata       <= '0;
            req_q           <= '0;
            rdata_lo_q      <= '0;
        end else begin
            req_ready       <= req_ready_next;
            resp_valid      <= resp_valid_next;
            resp_rdata      <= resp_rdata_next;
            resp_error      <= resp_error_next;
            bus_address     <= bus_address_next;
            bus_byte_enable <= bus_byte_enable_next;
            bus_read        <= bus_read_next;
            bus_write       <= bus_write_next;
            bus_wdata       <= bus_wdata_next;
            if (accept) begin
                req_q <= req_in;
            end
            // Low result byte of a split read arrives on the odd lane in the first cycle.
            if ((state_q == CYCLE1) && bus_ready) begin
                rdata_lo_q <= bus_rdata[DATA_W-1:BYTE_W];
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Bench for memory_bus_controller: byte-addressed memory model, expected bus-cycle queue and
// per-cycle compare of bus and response outputs, plus literal checks from the test plan.
module tb_memory_bus_controller;
`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [19:0] req_address;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_error;
    logic [19:0] bus_address;
    logic [1:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ready;

    memory_bus_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_word        (req_word),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .bus_address     (bus_address),
        .bus_byte_enable (bus_byte_enable),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .bus_ready       (bus_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [19:0] addr;
        logic [1:0]  be;
        logic        wr;
        logic [15:0] wd;
    } bus_cyc_t;

    logic [7:0] mem [logic [19:0]];
    bus_cyc_t   exp_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        chk_en = 1'b0;
    logic        busy = 1'b0;
    logic        resp_due = 1'b0;
    logic        resp_seen = 1'b0;
    logic        in_cycle = 1'b0;
    logic [15:0] pending_rdata = '0;
    logic [15:0] exp_resp_rdata = '0;
    logic        exp_resp_err = 1'b0;
    logic [15:0] model_rdata = '0;
    int          cfg_waits = 0;
    int          wait_left = 0;
    int          waits_seen = 0;
    int          ready_budget = -1;
    int          strobe_cnt = 0;
    int          accept_cyc = 0;
    int          resp_cyc = 0;
    logic [19:0] obs_addr = '0;
    logic [1:0]  obs_be = '0;
    logic [15:0] obs_wdata = '0;
    logic [15:0] obs_rdata = '0;
    logic        obs_err = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Memory-side responder and per-cycle comparison against the model.
    initial begin : bus_side
        bus_cyc_t    c;
        logic [19:0] ev;
        logic [19:0] od;
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                check("strobe_exclusive", 32'(bus_read & bus_write), 32'd0);
                check("resp_valid", 32'(resp_valid), 32'(resp_due));
                if (resp_due) begin
                    check("resp_rdata", 32'(resp_rdata), 32'(exp_resp_rdata));
                    check("resp_error", 32'(resp_error), 32'(exp_resp_err));
                    model_rdata = exp_resp_rdata;
                    obs_rdata   = resp_rdata;
                    obs_err     = resp_error;
                    resp_cyc    = cyc;
                    resp_seen   = 1'b1;
                    busy        = 1'b0;
                    resp_due    = 1'b0;
                end else begin
                    check("resp_rdata_hold", 32'(resp_rdata), 32'(model_rdata));
                end
                check("req_ready", 32'(req_ready), 32'(!busy));

                if (bus_read || bus_write) begin
                    strobe_cnt++;
                    if (exp_q.size() == 0) begin
                        check("strobe_when_idle", 32'(bus_read | bus_write), 32'd0);
                        bus_ready = 1'b0;
                    end else begin
                        c = exp_q[0];
                        check("bus_address", 32'(bus_address), 32'(c.addr));
                        check("bus_byte_enable", 32'(bus_byte_enable), 32'(c.be));
                        check("bus_write", 32'(bus_write), 32'(c.wr));
                        if (c.wr) check("bus_wdata", 32'(bus_wdata), 32'(c.wd));
                        if (!in_cycle) begin
                            in_cycle   = 1'b1;
                            wait_left  = cfg_waits;
                            waits_seen = 0;
                        end
                        if (ready_budget == 0 || wait_left > 0) begin
                            bus_ready = 1'b0;
                            bus_rdata = 16'hDEAD;
                            if (wait_left > 0) wait_left--;
                            waits_seen++;
`ifdef BUS_TIMEOUT_EN
                            if (waits_seen == int'(TB_TIMEOUT)) begin
                                exp_q.delete();
                                in_cycle       = 1'b0;
                                resp_due       = 1'b1;
                                exp_resp_rdata = 16'h0000;
                                exp_resp_err   = 1'b1;
                            end
`endif
                        end else begin
                            bus_ready = 1'b1;
                            in_cycle  = 1'b0;
                            if (ready_budget > 0) ready_budget--;
                            ev = {bus_address[19:1], 1'b0};
                            od = {bus_address[19:1], 1'b1};
                            if (bus_read) begin
                                bus_rdata = {rd(od), rd(ev)};
                            end else begin
                                if (bus_byte_enable[0]) mem[ev] = bus_wdata[7:0];
                                if (bus_byte_enable[1]) mem[od] = bus_wdata[15:8];
                            end
                            obs_addr  = bus_address;
                            obs_be    = bus_byte_enable;
                            obs_wdata = bus_wdata;
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                resp_due       = 1'b1;
                                exp_resp_rdata = pending_rdata;
                                exp_resp_err   = 1'b0;
                            end
                        end
                    end
                end else begin
                    in_cycle  = 1'b0;
                    bus_ready = 1'b1;
                    bus_rdata = 16'h5A5A;
                end
            end
        end
    end

    task automatic start_req(input logic t_wr, input logic t_word, input logic [19:0] a,
                             input logic [15:0] wd, input int waits, input int budget);
        logic [19:0] a1;
        logic        got;
        a1 = a + 20'd1;
        exp_q.delete();
        if (t_word && a[0]) begin
            exp_q.push_back('{addr: a,  be: 2'b10, wr: t_wr, wd: {wd[7:0], 8'h00}});
            exp_q.push_back('{addr: a1, be: 2'b01, wr: t_wr, wd: {8'h00, wd[15:8]}});
        end else if (t_word) begin
            exp_q.push_back('{addr: a, be: 2'b11, wr: t_wr, wd: wd});
        end else if (a[0]) begin
            exp_q.push_back('{addr: a, be: 2'b10, wr: t_wr, wd: {wd[7:0], 8'h00}});
        end else begin
            exp_q.push_back('{addr: a, be: 2'b01, wr: t_wr, wd: {8'h00, wd[7:0]}});
        end
        pending_rdata = t_wr ? 16'h0000 : (t_word ? {rd(a1), rd(a)} : {8'h00, rd(a)});
        cfg_waits    = waits;
        ready_budget = budget;
        strobe_cnt   = 0;
        resp_seen    = 1'b0;
        @(posedge clock);
        #1;
        req_valid   = 1'b1;
        req_write   = t_wr;
        req_word    = t_word;
        req_address = a;
        req_wdata   = wd;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = req_ready;
        end
        if (!got) check("req_accept_timeout", 32'(req_ready), 32'd1);
        accept_cyc = cyc;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        busy      = 1'b1;
    endtask

    task automatic wait_resp(input int exp_lat);
        for (int i = 0; i < 200 && !resp_seen; i++) @(negedge clock);
        if (!resp_seen) check("resp_timeout", 32'(resp_valid), 32'd1);
        else if (exp_lat >= 0) check("latency", 32'(resp_cyc - accept_cyc), 32'(exp_lat));
    endtask

    task automatic do_req(input logic t_wr, input logic t_word, input logic [19:0] a,
                          input logic [15:0] wd, input int waits, input int exp_lat);
        start_req(t_wr, t_word, a, wd, waits, -1);
        wait_resp(exp_lat);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_word    = 1'b0;
        req_address = '0;
        req_wdata   = '0;
        mem[20'h12344] = 8'hEF;
        mem[20'h12345] = 8'hBE;
        mem[20'hFFFFF] = 8'h34;
        mem[20'h00000] = 8'h12;
        mem[20'h00301] = 8'h11;
        mem[20'h00302] = 8'h22;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        check("rst_bus_read", 32'(bus_read), 32'd0);
        check("rst_bus_write", 32'(bus_write), 32'd0);
        check("rst_bus_be", 32'(bus_byte_enable), 32'd0);
        check("rst_bus_address", 32'(bus_address), 32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        do_req(1'b0, 1'b0, 20'h12344, 16'h0000, 0, 2);
        check("byte_read_even_data", 32'(obs_rdata), 32'h00EF);
        check("byte_read_even_be", 32'(obs_be), 32'h1);

        do_req(1'b1, 1'b0, 20'h00011, 16'h77A5, 0, 2);
        check("byte_write_odd_addr", 32'(obs_addr), 32'h00011);
        check("byte_write_odd_be", 32'(obs_be), 32'h2);
        check("byte_write_odd_lane", 32'(obs_wdata[15:8]), 32'hA5);
        check("byte_write_strobes", 32'(strobe_cnt), 32'd1);
        check("byte_write_mem", 32'(rd(20'h00011)), 32'hA5);

        do_req(1'b0, 1'b1, 20'hFFFFF, 16'h0000, 0, 3);
        check("wrap_read_data", 32'(obs_rdata), 32'h1234);
        check("wrap_read_addr2", 32'(obs_addr), 32'h00000);
        check("wrap_read_be2", 32'(obs_be), 32'h1);

        do_req(1'b1, 1'b1, 20'h20000, 16'hCAFE, 3, 5);
        check("wait_write_strobes", 32'(strobe_cnt), 32'd4);
        check("wait_write_be", 32'(obs_be), 32'h3);
        check("wait_write_mem", 32'({rd(20'h20001), rd(20'h20000)}), 32'hCAFE);

        do_req(1'b0, 1'b1, 20'h20000, 16'h0000, 2, 4);
        check("wait_read_data", 32'(obs_rdata), 32'hCAFE);

        do_req(1'b1, 1'b1, 20'h00101, 16'hBEEF, 0, 3);
        check("split_write_strobes", 32'(strobe_cnt), 32'd2);

        do_req(1'b0, 1'b1, 20'h00101, 16'h0000, 1, 5);
        check("split_read_data", 32'(obs_rdata), 32'hBEEF);

        do_req(1'b0, 1'b0, 20'h12345, 16'h0000, 0, 2);
        check("byte_read_odd_data", 32'(obs_rdata), 32'h00BE);

        // Reset while the second half of a split read is stalled.
        start_req(1'b0, 1'b1, 20'h00301, 16'h0000, 0, 1);
        repeat (2) @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        busy = 1'b0;
        exp_q.delete();
        resp_due     = 1'b0;
        in_cycle     = 1'b0;
        model_rdata  = 16'h0000;
        ready_budget = -1;
        @(negedge clock);
        check("midrst_bus_read", 32'(bus_read), 32'd0);
        check("midrst_bus_write", 32'(bus_write), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);

        do_req(1'b0, 1'b1, 20'h12344, 16'h0000, 0, 2);
        check("post_reset_read", 32'(obs_rdata), 32'hBEEF);

`ifdef BUS_TIMEOUT_EN
        start_req(1'b0, 1'b1, 20'h00400, 16'h0000, 0, 0);
        wait_resp(-1);
        check("timeout_error", 32'(obs_err), 32'd1);
        check("timeout_rdata", 32'(obs_rdata), 32'h0000);
        check("timeout_strobes", 32'(strobe_cnt), 32'(TB_TIMEOUT));
        ready_budget = -1;
        do_req(1'b0, 1'b0, 20'h12345, 16'h0000, 0, 2);
        check("after_timeout_read", 32'(obs_rdata), 32'h00BE);
`endif

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
- Consumes 20-bit physical addresses from the execution unit and runs the corresponding external memory bus cycles on a 16-bit data bus with byte enables.
- Splits odd-address word accesses into two byte cycles, with address wrap-around at 20 bits.
- Inserts wait states while the bus deasserts ready, and returns read data to the requester.
- Sits between the address/execute path and the external memory interface.

Parameters:
- TIMEOUT_CYCLES, 255: wait-state cycles per bus cycle before abort; used only with BUS_TIMEOUT_EN.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle and able to accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_word  input  1  1 = 16-bit access, 0 = 8-bit access.
- req_address  input  20  physical byte address.
- req_wdata  input  16  write data; a byte access uses [7:0].
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  16  read data; a byte read is zero-extended.
- resp_error  output  1  valid with resp_valid; 1 = timeout abort (constant 0 without the macro).
- bus_address  output  20  byte address of the current bus cycle.
- bus_byte_enable  output  2  [0] = even lane D[7:0], [1] = odd lane D[15:8].
- bus_read  output  1  read strobe.
- bus_write  output  1  write strobe.
- bus_wdata  output  16  write data.
- bus_rdata  input  16  read data; sampled when bus_ready=1.
- bus_ready  input  1  current bus cycle completes this clock.

Behaviour:
- Reset values: req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0; bus_read=0; bus_write=0; bus_byte_enable=0; bus_address=0; bus_wdata=0; state IDLE.
- States are IDLE, CYCLE1 and CYCLE2. req_ready=1 only in IDLE.
- Acceptance: req_valid & req_ready at edge T. Request fields are latched. State goes to CYCLE1. Strobes, address and enables are registered and valid from T+1.
- Lane mapping, per bus cycle:
  - Even-address byte: BE=01, bus_wdata={8'h00, b}, read result takes D[7:0].
  - Odd-address byte: BE=10, bus_wdata={b, 8'h00}, read result takes D[15:8].
  - Even-address word: BE=11, bus_wdata=req_wdata, read result takes D[15:0].
- Odd-address word, CYCLE1:
  - Address A, BE=10, bus_wdata[15:8]=wdata[7:0].
  - On read, D[15:8] goes to result[7:0].
- Odd-address word, CYCLE2:
  - Address (A+1) mod 2^20, BE=01, bus_wdata[7:0]=wdata[15:8].
  - On read, D[7:0] goes to result[15:8].
  - A=20'hFFFFF gives a CYCLE2 address of 20'h00000.
- Wait states: the strobe, address, enables and wdata are held constant while bus_ready=0. There is no limit without the macro.
- CYCLE1 completing at edge E:
  - Split access: state goes to CYCLE2. The strobe stays high at E+1 with the new address and enables; there is no idle gap.
  - Otherwise: state goes to IDLE. Strobes drop at E+1.
- Final completion at edge E (bus_ready=1 in CYCLE2, or in CYCLE1 for a non-split access):
  - resp_valid=1 during E+1, together with resp_rdata and req_ready=1.
  - A new request can be accepted at the end of E+1.
- Minimum latency, zero wait states: response 2 cycles after acceptance for aligned or byte accesses; 3 cycles for a split word.
- resp_rdata holds its last value when resp_valid=0.
- Write responses return resp_rdata=0.
- bus_read and bus_write are never high together.
- bus_ready while no strobe is high is ignored.
- req_valid while not ready is ignored; the requester must hold the request.
- Reset mid-operation: at the reset edge the state returns to IDLE and all outputs take reset values. No resp_valid is produced for the aborted access. A half-completed split write is not undone.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared at every strobe start and at every bus_ready.
  - If the counter reaches TIMEOUT_CYCLES wait cycles with bus_ready=0, the access aborts. Strobes drop next cycle, resp_valid=1 with resp_error=1 and resp_rdata=0, and state returns to IDLE.
  - An abort in CYCLE1 of a split access skips CYCLE2.
- Undefined: no counter; bus_ready is waited for indefinitely; resp_error is tied to 0.

Test Plan:
- Byte read at 20'h12344, bus_rdata=16'hBEEF, zero waits: BE=01 at T+1; resp_rdata=16'h00EF at T+2.
- Byte write 8'hA5 at 20'h00011: bus_address=20'h00011, BE=10, bus_wdata[15:8]=8'hA5, bus_write for 1 cycle.
- Word read at 20'hFFFFF: cycle 1 is FFFFF/BE=10 with D[15:8]=8'h34, cycle 2 is 00000/BE=01 with D[7:0]=8'h12; resp_rdata=16'h1234 at T+3.
- Aligned word write 16'hCAFE at 20'h20000 with bus_ready low for 3 cycles: outputs held stable 4 cycles; resp_valid exactly 1 cycle; req_ready only afterwards.
- reset asserted during a CYCLE2 wait state: the next cycle shows all strobes 0, req_ready=1 and no resp_valid. A new read then completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready held 0: abort after 4 waits; resp_valid=1, resp_error=1, resp_rdata=16'h0000.
